// File: rtl/filters_tap_sequencer.sv
// Circular-history tap sequencer for FIR filters: writes each accepted sample into
// an external filters_ram ring and streams the NTAPS newest samples, newest first.
// Optional feature macro: FILTERS_TAP_SEQ_CLEAR_EN (zero the ring after reset).
module filters_tap_sequencer #(
    parameter int DWIDTH = 16,
    parameter int NTAPS  = 8,
    parameter int AWIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] sample_i,
    input  logic              sample_valid_i,
    output logic              sample_ready_o,
    output logic [AWIDTH-1:0] ram_wraddr_o,
    output logic [AWIDTH-1:0] ram_rdaddr_o,
    output logic              ram_wren_o,
    output logic [DWIDTH-1:0] ram_d_o,
    input  logic [DWIDTH-1:0] ram_q_i,
    output logic [DWIDTH-1:0] tap_o,
    output logic [AWIDTH-1:0] tap_idx_o,
    output logic              tap_valid_o,
    output logic              tap_last_o
);

`ifdef FILTERS_TAP_SEQ_CLEAR_EN
    typedef enum logic [1:0] {INIT, IDLE, READ, CLEAR} state_t;
`else
    typedef enum logic [1:0] {INIT, IDLE, READ} state_t;
`endif

    localparam logic [AWIDTH-1:0] LAST_K = AWIDTH'(NTAPS - 1);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [AWIDTH-1:0] base_q, base_d;
    logic [AWIDTH-1:0] tapK_q, tapK_d;
    logic              tapValid_q, tapValid_d;
    logic [AWIDTH-1:0] tapIdx_q, tapIdx_d;
    logic              tapLast_q, tapLast_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            wrPtr_q    <= '0;
            base_q     <= '0;
            tapK_q     <= '0;
            tapValid_q <= 1'b0;
            tapIdx_q   <= '0;
            tapLast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            base_q     <= base_d;
            tapK_q     <= tapK_d;
            tapValid_q <= tapValid_d;
            tapIdx_q   <= tapIdx_d;
            tapLast_q  <= tapLast_d;
        end
    end

    // Tap flags are captured at read issue so they line up with the RAM's registered q.
    always_comb begin
        state_d        = state_q;
        wrPtr_d        = wrPtr_q;
        base_d         = base_q;
        tapK_d         = tapK_q;
        tapValid_d     = 1'b0;
        tapIdx_d       = '0;
        tapLast_d      = 1'b0;
        sample_ready_o = 1'b0;
        ram_wren_o     = 1'b0;
        ram_rdaddr_o   = '0;
        ram_d_o        = sample_i;
        case (state_q)
            INIT: begin
`ifdef FILTERS_TAP_SEQ_CLEAR_EN
                state_d = CLEAR;
`else
                state_d = IDLE;
`endif
            end
            IDLE: begin
                sample_ready_o = 1'b1;
                if (sample_valid_i) begin
                    ram_wren_o = 1'b1;
                    base_d     = wrPtr_q;
                    wrPtr_d    = wrPtr_q + AWIDTH'(1);
                    tapK_d     = '0;
                    state_d    = READ;
                end
            end
            READ: begin
                ram_rdaddr_o = base_q - tapK_q;
                tapK_d       = tapK_q + AWIDTH'(1);
                tapValid_d   = 1'b1;
                tapIdx_d     = tapK_q;
                tapLast_d    = (tapK_q == LAST_K);
                if (tapK_q == LAST_K) begin
                    state_d = IDLE;
                end
            end
`ifdef FILTERS_TAP_SEQ_CLEAR_EN
            // The write pointer doubles as the clear address and wraps back to 0 when done.
            CLEAR: begin
                ram_wren_o = 1'b1;
                ram_d_o    = '0;
                wrPtr_d    = wrPtr_q + AWIDTH'(1);
                if (wrPtr_q == '1) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = INIT;
        endcase
    end

    assign ram_wraddr_o = wrPtr_q;
    assign tap_o        = ram_q_i;
    assign tap_valid_o  = tapValid_q;
    assign tap_idx_o    = tapIdx_q;
    assign tap_last_o   = tapLast_q;

endmodule
